prince_sbox_layer_ti4: RTL and testbench



---
 rtl/prince_sbox_layer_ti4.sv | 227 ++++++++++++++++++++++
 tb/tb_prince_sbox_layer_ti4.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prince_sbox_layer_ti4.sv
`default_nettype none
// ============================================================================
// Module   : prince_sbox_layer_ti4
// Purpose  : Registered 4-share threshold implementation of the PRINCE S-box
//            layer. Each nibble's four output shares are non-complete
//            degree-3 component functions. A 4-bit guard is XORed into each
//            share; consecutive nibbles chain their guards, so one layer call
//            needs only 12 fresh random bits. PIPE=2 inserts a register on the
//            per-share monomial terms ahead of the XOR tree and guard XOR.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid          - qualifies in_w..in_z and rnd
//            in_w/x/y/z [W]    - input shares, nibble k at bits 4k+3:4k
//            rnd [12]          - guard randomness for nibble 0
//            out_valid         - in_valid delayed by PIPE cycles
//            out_w/x/y/z [W]   - registered output shares
// Revision : 1.0 - initial release
// ============================================================================
module prince_sbox_layer_ti4 #(
  parameter int NIBBLES = 16,
  parameter int PIPE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [4*NIBBLES-1:0]   in_w,
  input  logic [4*NIBBLES-1:0]   in_x,
  input  logic [4*NIBBLES-1:0]   in_y,
  input  logic [4*NIBBLES-1:0]   in_z,
  input  logic [11:0]            rnd,
  output logic                   out_valid,
  output logic [4*NIBBLES-1:0]   out_w,
  output logic [4*NIBBLES-1:0]   out_x,
  output logic [4*NIBBLES-1:0]   out_y,
  output logic [4*NIBBLES-1:0]   out_z
);

  localparam int W = 4 * NIBBLES;

  // S-box table, entry i at bits 4i+3:4i (S(0)=B ... S(F)=4).
  localparam logic [63:0] C_SBOX = 64'h4D5E_0876_19CA_23FB;

  // Algebraic normal form of each S-box output bit, obtained by Moebius
  // transform of the table. Bit 16*j+u is the coefficient of monomial u
  // (set of input bits) in output bit j. A permutation has no degree-4 term.
  function automatic logic [63:0] anf_table();
    logic [63:0] a;
    a = '0;
    for (int j = 0; j < 4; j++) begin
      for (int u = 0; u < 16; u++) begin
        for (int v = 0; v < 16; v++) begin
          if ((v & ~u) == 0) a[16*j+u] = a[16*j+u] ^ C_SBOX[4*v+j];
        end
      end
    end
    return a;
  endfunction

  localparam logic [63:0] C_ANF = anf_table();

  // For every monomial u, the share of its expanded product that belongs to
  // output share owner_sel. Expanding a monomial over the input shares gives
  // one cross product per assignment of a share index to each variable; the
  // product is owned by the lowest share index it does not touch, so output
  // share o never sees input share o. sh holds input share s at bits 4s+3:4s.
  function automatic logic [15:0] partial_terms(input logic [1:0]  owner_sel,
                                                input logic [15:0] sh);
    logic [15:0] t;
    logic [3:0]  uv;
    logic [7:0]  cv;
    logic [7:0]  cmask;
    logic [3:0]  used;
    logic [1:0]  s;
    logic [1:0]  owner;
    logic        prod;
    logic        ok;
    t = '0;
    for (int u = 0; u < 16; u++) begin
      uv    = u[3:0];
      cmask = '0;
      for (int i = 0; i < 4; i++) begin
        if (!uv[i]) cmask[2*i+:2] = 2'b11;
      end
      for (int c = 0; c < 256; c++) begin
        cv = c[7:0];
        if ((cv & cmask) == 8'd0) begin
          used = '0;
          prod = 1'b1;
          for (int i = 0; i < 4; i++) begin
            s = cv[2*i+:2];
            if (uv[i]) begin
              used[s] = 1'b1;
              prod    = prod & sh[4*s+i];
            end
          end
          ok    = 1'b1;
          owner = 2'd0;
          if (!used[0])      owner = 2'd0;
          else if (!used[1]) owner = 2'd1;
          else if (!used[2]) owner = 2'd2;
          else if (!used[3]) owner = 2'd3;
          else               ok    = 1'b0;
          if (ok && (owner == owner_sel)) t[u] = t[u] ^ prod;
        end
      end
    end
    return t;
  endfunction

  // XOR tree: combine the monomial terms of one share into its 4 output bits.
  function automatic logic [3:0] component(input logic [15:0] t);
    logic [3:0] y;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      for (int u = 0; u < 16; u++) begin
        y[j] = y[j] ^ (C_ANF[16*j+u] & t[u]);
      end
    end
    return y;
  endfunction

  // --------------------------------------------------------------------------
  // Valid tracking
  // --------------------------------------------------------------------------
  logic [PIPE-1:0] r_valid;

  generate
    if (PIPE == 2) begin : g_valid_pipe2
      always_ff @(posedge clk) begin
        if (rst) r_valid <= '0;
        else     r_valid <= {r_valid[0], in_valid};
      end
    end else begin : g_valid_pipe1
      always_ff @(posedge clk) begin
        if (rst) r_valid <= '0;
        else     r_valid <= in_valid;
      end
    end
  endgenerate

  assign out_valid = r_valid[PIPE-1];

  // --------------------------------------------------------------------------
  // Guard sources: nibble 0 from rnd, nibble k from input shares of nibble k-1
  // --------------------------------------------------------------------------
  logic [W-1:0] w_guard_a;
  logic [W-1:0] w_guard_b;
  logic [W-1:0] w_guard_c;

  assign w_guard_a[3:0] = rnd[3:0];
  assign w_guard_b[3:0] = rnd[7:4];
  assign w_guard_c[3:0] = rnd[11:8];

  generate
    if (NIBBLES > 1) begin : g_chain
      assign w_guard_a[W-1:4] = in_w[W-5:0];
      assign w_guard_b[W-1:4] = in_x[W-5:0];
      assign w_guard_c[W-1:4] = in_y[W-5:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Per-nibble shared S-box
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NIBBLES; k++) begin : g_nibble
      logic [15:0]      w_sh;
      logic [3:0][15:0] w_terms;
      logic [3:0][3:0]  w_guard;
      logic [3:0][15:0] w_terms_st;
      logic [3:0][3:0]  w_guard_st;
      logic             w_load;
      logic [3:0][3:0]  r_share;

      assign w_sh = {in_z[4*k+:4], in_y[4*k+:4], in_x[4*k+:4], in_w[4*k+:4]};

      always_comb begin
        w_terms = '0;
        for (int o = 0; o < 4; o++) w_terms[o] = partial_terms(2'(o), w_sh);
      end

      // Guards XOR to zero across the four shares.
      assign w_guard[0] = w_guard_a[4*k+:4];
      assign w_guard[1] = w_guard_b[4*k+:4];
      assign w_guard[2] = w_guard_c[4*k+:4];
      assign w_guard[3] = w_guard_a[4*k+:4] ^ w_guard_b[4*k+:4] ^ w_guard_c[4*k+:4];

      if (PIPE == 2) begin : g_stage
        logic [3:0][15:0] r_terms;
        logic [3:0][3:0]  r_guard;

        always_ff @(posedge clk) begin
          if (rst) begin
            r_terms <= '0;
            r_guard <= '0;
          end else if (in_valid) begin
            r_terms <= w_terms;
            r_guard <= w_guard;
          end
        end

        assign w_terms_st = r_terms;
        assign w_guard_st = r_guard;
        assign w_load     = r_valid[0];
      end else begin : g_direct
        assign w_terms_st = w_terms;
        assign w_guard_st = w_guard;
        assign w_load     = in_valid;
      end

      // Holding on idle cycles keeps share combinations from toggling.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_share <= '0;
        end else if (w_load) begin
          for (int o = 0; o < 4; o++) r_share[o] <= component(w_terms_st[o]) ^ w_guard_st[o];
        end
      end

      assign out_w[4*k+:4] = r_share[0];
      assign out_x[4*k+:4] = r_share[1];
      assign out_y[4*k+:4] = r_share[2];
      assign out_z[4*k+:4] = r_share[3];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prince_sbox_layer_ti4.sv
`default_nettype none
// ============================================================================
// Module   : tb_prince_sbox_layer_ti4
// Purpose  : Self-checking bench for prince_sbox_layer_ti4. Three instances
//            (16 nibbles/PIPE=1, 16 nibbles/PIPE=2, 1 nibble/PIPE=1) share one
//            stimulus stream. A table-driven model predicts the unshared
//            output of every accepted call and when it must appear; outputs
//            must hold when no result is due and be zero under reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prince_sbox_layer_ti4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_w, in_x, in_y, in_z;
  logic [11:0] rnd;

  logic        ov1, ov2, ov3;
  logic [63:0] o1w, o1x, o1y, o1z;
  logic [63:0] o2w, o2x, o2y, o2z;
  logic [3:0]  o3w, o3x, o3y, o3z;

  always #5 clk = ~clk;

  prince_sbox_layer_ti4 #(.NIBBLES(16), .PIPE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z), .rnd(rnd),
    .out_valid(ov1), .out_w(o1w), .out_x(o1x), .out_y(o1y), .out_z(o1z));

  prince_sbox_layer_ti4 #(.NIBBLES(16), .PIPE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z), .rnd(rnd),
    .out_valid(ov2), .out_w(o2w), .out_x(o2x), .out_y(o2y), .out_z(o2z));

  prince_sbox_layer_ti4 #(.NIBBLES(1), .PIPE(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_w(in_w[3:0]), .in_x(in_x[3:0]), .in_y(in_y[3:0]), .in_z(in_z[3:0]), .rnd(rnd),
    .out_valid(ov3), .out_w(o3w), .out_x(o3x), .out_y(o3y), .out_z(o3z));

  int checks = 0;
  int fails  = 0;

  function automatic logic [3:0] sbox(input logic [3:0] v);
    case (v)
      4'h0: sbox = 4'hB; 4'h1: sbox = 4'hF; 4'h2: sbox = 4'h3; 4'h3: sbox = 4'h2;
      4'h4: sbox = 4'hA; 4'h5: sbox = 4'hC; 4'h6: sbox = 4'h9; 4'h7: sbox = 4'h1;
      4'h8: sbox = 4'h6; 4'h9: sbox = 4'h7; 4'hA: sbox = 4'h8; 4'hB: sbox = 4'h0;
      4'hC: sbox = 4'hE; 4'hD: sbox = 4'h5; 4'hE: sbox = 4'hD; default: sbox = 4'h4;
    endcase
  endfunction

  function automatic logic [63:0] layer(input logic [63:0] s);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n+:4] = sbox(s[4*n+:4]);
    return r;
  endfunction

  typedef struct packed {
    int          due;
    logic [63:0] data;
  } ent_t;

  ent_t        q1[$], q2[$], q3[$];
  int          edge_n = 0;
  logic [63:0] prev[3][4];

  task automatic check(input int d, input logic was_rst, input logic ov,
                       input logic [63:0] w, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] z,
                       input logic h, input logic [63:0] ex);
    checks++;
    if (ov !== h) begin
      fails++;
      $display("FAIL valid dut%0d edge %0d: got %b want %b", d + 1, edge_n, ov, h);
    end
    checks++;
    if (h) begin
      if ((w ^ x ^ y ^ z) !== ex) begin
        fails++;
        $display("FAIL unshare dut%0d edge %0d: got %h want %h", d + 1, edge_n, w ^ x ^ y ^ z, ex);
      end
    end else if (was_rst) begin
      if ((w | x | y | z) !== 64'd0) begin
        fails++;
        $display("FAIL rst_zero dut%0d edge %0d: got %h %h %h %h want 0", d + 1, edge_n, w, x, y, z);
      end
    end else begin
      if (w !== prev[d][0] || x !== prev[d][1] || y !== prev[d][2] || z !== prev[d][3]) begin
        fails++;
        $display("FAIL hold dut%0d edge %0d: got %h %h %h %h want %h %h %h %h", d + 1, edge_n,
                 w, x, y, z, prev[d][0], prev[d][1], prev[d][2], prev[d][3]);
      end
    end
    prev[d][0] = w; prev[d][1] = x; prev[d][2] = y; prev[d][3] = z;
  endtask

  // Model update at the edge, comparison 1 time unit later.
  always @(posedge clk) begin
    logic        r_now;
    logic [63:0] u;
    ent_t        e;
    logic        h;
    logic [63:0] ex;
    edge_n = edge_n + 1;
    r_now  = rst;
    u      = layer(in_w ^ in_x ^ in_y ^ in_z);
    if (r_now) begin
      q1.delete(); q2.delete(); q3.delete();
    end else if (in_valid) begin
      e.data = u;                e.due = edge_n;     q1.push_back(e);
      e.data = u;                e.due = edge_n + 1; q2.push_back(e);
      e.data = {60'd0, u[3:0]};  e.due = edge_n;     q3.push_back(e);
    end
    #1;
    h = 1'b0; ex = '0;
    if (q1.size() > 0 && q1[0].due == edge_n) begin h = 1'b1; e = q1.pop_front(); ex = e.data; end
    check(0, r_now, ov1, o1w, o1x, o1y, o1z, h, ex);
    h = 1'b0; ex = '0;
    if (q2.size() > 0 && q2[0].due == edge_n) begin h = 1'b1; e = q2.pop_front(); ex = e.data; end
    check(1, r_now, ov2, o2w, o2x, o2y, o2z, h, ex);
    h = 1'b0; ex = '0;
    if (q3.size() > 0 && q3[0].due == edge_n) begin h = 1'b1; e = q3.pop_front(); ex = e.data; end
    check(2, r_now, ov3, {60'd0, o3w}, {60'd0, o3x}, {60'd0, o3y}, {60'd0, o3z}, h, ex);
  end

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic apply(input logic v, input logic [63:0] s, input logic [11:0] r);
    in_w     = r64();
    in_x     = r64();
    in_y     = r64();
    in_z     = s ^ in_w ^ in_x ^ in_y;
    in_valid = v;
    rnd      = r;
    tick();
  endtask

  initial begin
    logic [3:0] saved;
    for (int d = 0; d < 3; d++) for (int s = 0; s < 4; s++) prev[d][s] = '0;
    rst = 1'b1; in_valid = 1'b1;
    in_w = r64(); in_x = r64(); in_y = r64(); in_z = r64(); rnd = 12'(($urandom));

    // Reset with live inputs, then one idle cycle after release.
    tick();
    apply(1'b1, r64(), 12'($urandom()));
    rst = 1'b0;
    apply(1'b0, r64(), 12'($urandom()));
    lit("post_rst_valid", {63'd0, ov1}, 64'd0);
    lit("post_rst_w", o1w, 64'd0);

    // Functional sweep.
    apply(1'b1, 64'h0123_4567_89AB_CDEF, 12'($urandom()));
    lit("sweep_valid", {63'd0, ov1}, 64'd1);
    lit("sweep_layer", o1w ^ o1x ^ o1y ^ o1z, 64'hBF32_AC91_6780_E5D4);
    lit("sweep_nib1", {60'd0, o3w ^ o3x ^ o3y ^ o3z}, 64'h4);

    // Guard cancellation with a fixed sharing of the zero state.
    in_w = r64(); in_x = r64(); in_y = r64(); in_z = in_w ^ in_x ^ in_y;
    in_valid = 1'b1;
    rnd = 12'h000; tick();
    lit("guard_000", o1w ^ o1x ^ o1y ^ o1z, 64'hBBBB_BBBB_BBBB_BBBB);
    saved = o1w[3:0];
    rnd = 12'hFFF; tick();
    lit("guard_fff", o1w ^ o1x ^ o1y ^ o1z, 64'hBBBB_BBBB_BBBB_BBBB);
    lit("guard_w0_delta", {60'd0, o1w[3:0] ^ saved}, 64'hF);
    rnd = 12'hA5A; tick();
    lit("guard_a5a", o1w ^ o1x ^ o1y ^ o1z, 64'hBBBB_BBBB_BBBB_BBBB);

    // Chained guard: moving input share w of nibble 0 shifts out_w of nibble 1.
    rnd = 12'h000; tick();
    saved = o1w[7:4];
    in_w[3:0] = in_w[3:0] ^ 4'h5;
    in_z[3:0] = in_z[3:0] ^ 4'h5;
    tick();
    lit("chain_w1_delta", {60'd0, o1w[7:4] ^ saved}, 64'h5);

    // Back-to-back calls, then idle cycles with changing data.
    apply(1'b0, r64(), 12'($urandom()));
    for (int i = 0; i < 5; i++) apply(1'b1, r64(), 12'($urandom()));
    for (int i = 0; i < 3; i++) apply(1'b0, r64(), 12'($urandom()));
    apply(1'b0, r64(), 12'($urandom()));

    // Reset while a PIPE=2 result is in flight.
    apply(1'b1, r64(), 12'($urandom()));
    rst = 1'b1;
    apply(1'b0, r64(), 12'($urandom()));
    rst = 1'b0;
    apply(1'b0, r64(), 12'($urandom()));
    lit("midrst_no_valid", {63'd0, ov2}, 64'd0);
    apply(1'b0, r64(), 12'($urandom()));
    apply(1'b1, r64(), 12'($urandom()));
    lit("midrst_lat1", {63'd0, ov2}, 64'd0);
    apply(1'b0, r64(), 12'($urandom()));
    lit("midrst_lat2", {63'd0, ov2}, 64'd1);

    // Every single-nibble value under several sharings.
    for (int v = 0; v < 16; v++) begin
      for (int r = 0; r < 8; r++) begin
        apply(1'b1, {r64() >> 4, 4'(v)}, 12'($urandom()));
      end
    end
    for (int i = 0; i < 3; i++) apply(1'b0, r64(), 12'($urandom()));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
